// File: rtl/vec_addsub_pipe_if.sv
// Handshake and data bundle for vec_addsub_pipe.
// master = upstream/downstream environment, slave = the engine.
interface vec_addsub_pipe_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y [N];
  logic [N-1:0] out_flag;

  modport master (
    output in_valid, in_op, a, b, out_ready,
    input  in_ready, out_valid, y, out_flag
  );

  modport slave (
    input  in_valid, in_op, a, b, out_ready,
    output in_ready, out_valid, y, out_flag
  );
endinterface

// File: rtl/vec_addsub_pipe.sv
// N-lane W-bit unsigned add/sub pipeline, STAGES deep, with a global stall.
// Optional saturation for opcodes 10/11 is enabled by defining VEC_ADDSUB_SAT_EN.
module vec_addsub_pipe #(
  parameter int W      = 8,
  parameter int N      = 4,
  parameter int STAGES = 3
) (
  input  logic              clock,
  input  logic              reset,
  vec_addsub_pipe_if.slave  bus
);

  logic                  v0_q;
  logic [1:0]            op0_q;
  logic [N-1:0][W-1:0]   a0_q;
  logic [N-1:0][W-1:0]   b0_q;

  logic [STAGES-1:1]     v_q;
  logic [N-1:0][W-1:0]   y_q [1:STAGES-1];
  logic [N-1:0]          f_q [1:STAGES-1];

  logic [W:0]            raw_d [N];
  logic [N-1:0][W-1:0]   res_d;
  logic [N-1:0]          flag_d;
  logic                  advance_s;

  // Whole pipe moves together; a stalled valid output freezes every stage.
  assign advance_s    = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = reset && advance_s;

  // Per-lane W+1 bit sum/difference; bit W is carry (add) or borrow (sub).
  always_comb begin
    res_d  = '0;
    flag_d = '0;
    for (int l = 0; l < N; l++) begin
      if (op0_q[0]) begin
        raw_d[l] = {1'b0, a0_q[l]} - {1'b0, b0_q[l]};
      end else begin
        raw_d[l] = {1'b0, a0_q[l]} + {1'b0, b0_q[l]};
      end
      flag_d[l] = raw_d[l][W];
`ifdef VEC_ADDSUB_SAT_EN
      if (op0_q[1] && raw_d[l][W]) begin
        res_d[l] = op0_q[0] ? {W{1'b0}} : {W{1'b1}};
      end else begin
        res_d[l] = raw_d[l][W-1:0];
      end
`else
      res_d[l] = raw_d[l][W-1:0];
`endif
    end
  end

  // Stage 0 capture, stage 1 compute, remaining stages delay.
  always_ff @(posedge clock) begin
    if (!reset) begin
      v0_q  <= 1'b0;
      op0_q <= 2'b00;
      a0_q  <= '0;
      b0_q  <= '0;
      v_q   <= '0;
      for (int s = 1; s < STAGES; s++) begin
        y_q[s] <= '0;
        f_q[s] <= '0;
      end
    end else if (advance_s) begin
      v0_q <= bus.in_valid;
      if (bus.in_valid) begin
        op0_q <= bus.in_op;
        for (int l = 0; l < N; l++) begin
          a0_q[l] <= bus.a[l];
          b0_q[l] <= bus.b[l];
        end
      end
      v_q[1] <= v0_q;
      y_q[1] <= res_d;
      f_q[1] <= flag_d;
      for (int s = 2; s < STAGES; s++) begin
        v_q[s] <= v_q[s-1];
        y_q[s] <= y_q[s-1];
        f_q[s] <= f_q[s-1];
      end
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.out_flag  = f_q[STAGES-1];

  for (genvar l = 0; l < N; l++) begin : g_out
    assign bus.y[l] = y_q[STAGES-1][l];
  end

endmodule

// File: tb/tb_vec_addsub_pipe.sv
// Scoreboard bench for vec_addsub_pipe (W=8, N=4, STAGES=3).
module tb_vec_addsub_pipe;
  localparam int W      = 8;
  localparam int N      = 4;
  localparam int STAGES = 3;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef logic [N+N*W-1:0]    exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  vec_addsub_pipe_if #(.W(W), .N(N)) bus ();
  vec_addsub_pipe #(.W(W), .N(N), .STAGES(STAGES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   out_cnt  = 0;
  exp_t sb [$];
  int   acc_cyc [$];
  int   out_cyc [$];
  logic prev_stall = 1'b0;
  vec_t prev_y;
  logic [N-1:0] prev_f;

  function automatic exp_t model(input logic [1:0] op, input vec_t av, input vec_t bv);
    vec_t         yv;
    logic [N-1:0] fv;
    for (int l = 0; l < N; l++) begin
      int unsigned ai = av[l];
      int unsigned bi = bv[l];
      int unsigned r;
      bit          f;
      if (!op[0]) begin
        r = ai + bi;
        f = (r >= (1 << W));
        r = r % (1 << W);
`ifdef VEC_ADDSUB_SAT_EN
        if (op[1] && f) r = (1 << W) - 1;
`endif
      end else begin
        f = (ai < bi);
        r = (ai + (1 << W) - bi) % (1 << W);
`ifdef VEC_ADDSUB_SAT_EN
        if (op[1] && f) r = 0;
`endif
      end
      yv[l] = r[W-1:0];
      fv[l] = f;
    end
    return {fv, yv};
  endfunction

  function automatic vec_t cur_y();
    vec_t v;
    for (int l = 0; l < N; l++) v[l] = bus.y[l];
    return v;
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input vec_t av, input vec_t bv);
    bus.in_valid = v;
    bus.in_op    = op;
    for (int l = 0; l < N; l++) begin
      bus.a[l] = av[l];
      bus.b[l] = bv[l];
    end
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int l = 0; l < N; l++) v[l] = W'($urandom_range(0, (1 << W) - 1));
    return v;
  endfunction

  // Scoreboard monitor: handshake rule, hold-on-stall, ordered result compare.
  always @(negedge clock) begin
    vec_t ycur;
    exp_t e;
    cyc++;
    ycur = cur_y();
    if (reset) begin
      checks++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        failures++;
        $display("FAIL in_ready_rule cyc=%0d got=%b want=%b", cyc, bus.in_ready, (!bus.out_valid || bus.out_ready));
      end
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || ycur !== prev_y || bus.out_flag !== prev_f) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got v=%b y=%h f=%b want v=1 y=%h f=%b", cyc, bus.out_valid, ycur, bus.out_flag, prev_y, prev_f);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        out_cnt++;
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL spurious_output cyc=%0d got y=%h f=%b want none", cyc, ycur, bus.out_flag);
        end else begin
          e = sb.pop_front();
          if ({bus.out_flag, ycur} !== e) begin
            failures++;
            $display("FAIL result cyc=%0d got %h want %h", cyc, {bus.out_flag, ycur}, e);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        vec_t av, bv;
        for (int l = 0; l < N; l++) begin
          av[l] = bus.a[l];
          bv[l] = bus.b[l];
        end
        sb.push_back(model(bus.in_op, av, bv));
        acc_cyc.push_back(cyc);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y     = ycur;
      prev_f     = bus.out_flag;
    end else begin
      sb.delete();
      prev_stall = 1'b0;
    end
  end

  task automatic wait_drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || bus.out_valid) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b00, rnd_vec(), rnd_vec());
    bus.out_ready = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || cur_y() !== '0 || bus.out_flag !== '0) begin
        failures++;
        $display("FAIL reset_state got rdy=%b v=%b y=%h f=%b want 0 0 0 0", bus.in_ready, bus.out_valid, cur_y(), bus.out_flag);
      end
    end
    @(posedge clock); #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_reset got rdy=%b v=%b want 1 0", bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_add_wrap();
    vec_t av, bv;
    int   got = 0;
    av[0] = 8'd255; av[1] = 8'd1; av[2] = 8'd100; av[3] = 8'd0;
    bv[0] = 8'd1;   bv[1] = 8'd2; bv[2] = 8'd27;  bv[3] = 8'd0;
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b00, av, bv);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    for (int c = 1; c <= STAGES + 3; c++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        got = c;
        break;
      end
    end
    checks++;
    if (got != STAGES) begin
      failures++;
      $display("FAIL add_latency got=%0d want=%0d", got, STAGES);
    end
    checks++;
    if (bus.y[0] !== 8'd0 || bus.y[1] !== 8'd3 || bus.y[2] !== 8'd127 || bus.y[3] !== 8'd0 || bus.out_flag !== 4'b0001) begin
      failures++;
      $display("FAIL add_wrap got y=%h f=%b want y=007f0300 f=0001", cur_y(), bus.out_flag);
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    vec_t a1, b1, a2, b2;
    logic [W-1:0] want [2];
    int   k = 0;
    a1 = rnd_vec(); b1 = rnd_vec(); a2 = rnd_vec(); b2 = rnd_vec();
    a1[0] = 8'd200; b1[0] = 8'd100;
    a2[0] = 8'd5;   b2[0] = 8'd9;
`ifdef VEC_ADDSUB_SAT_EN
    want[0] = 8'd255; want[1] = 8'd0;
`else
    want[0] = 8'd44;  want[1] = 8'd252;
`endif
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, a1, b1);
    @(posedge clock); #1;
    drive(1'b1, 2'b11, a2, b2);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        checks++;
        if (bus.y[0] !== want[k] || bus.out_flag[0] !== 1'b1) begin
          failures++;
          $display("FAIL sat_lane0 idx=%0d got y=%0d f=%b want y=%0d f=1", k, bus.y[0], bus.out_flag[0], want[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 2) begin
      failures++;
      $display("FAIL sat_count got=%0d want=2", k);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic pat [4];
    int   i = 0;
    int   start_cnt = out_cnt;
    logic acc;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    @(posedge clock); #1;
    drive(1'b1, 2'($urandom_range(0, 3)), rnd_vec(), rnd_vec());
    for (int c = 0; c < 200 && i < 8; c++) begin
      bus.out_ready = pat[c % 4];
      @(negedge clock);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clock); #1;
      if (acc) begin
        i++;
        if (i == 8) bus.in_valid = 1'b0;
        else drive(1'b1, 2'($urandom_range(0, 3)), rnd_vec(), rnd_vec());
      end
    end
    bus.in_valid = 1'b0;
    wait_drain();
    checks++;
    if (out_cnt - start_cnt != 8) begin
      failures++;
      $display("FAIL bp_count got=%0d want=8", out_cnt - start_cnt);
    end
  endtask

  task automatic test_throughput();
    @(posedge clock); #1;
    acc_cyc.delete();
    out_cyc.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'(i % 4), rnd_vec(), rnd_vec());
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    wait_drain();
    checks++;
    if (out_cyc.size() != 16 || acc_cyc.size() != 16) begin
      failures++;
      $display("FAIL tput_count got out=%0d acc=%0d want 16 16", out_cyc.size(), acc_cyc.size());
    end else begin
      checks++;
      if (out_cyc[15] - out_cyc[0] != 15) begin
        failures++;
        $display("FAIL tput_span got=%0d want=15", out_cyc[15] - out_cyc[0]);
      end
      checks++;
      if (out_cyc[0] - acc_cyc[0] != STAGES) begin
        failures++;
        $display("FAIL tput_first_latency got=%0d want=%0d", out_cyc[0] - acc_cyc[0], STAGES);
      end
    end
  endtask

  task automatic test_midflight_reset();
    int start_cnt;
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b00, rnd_vec(), rnd_vec());
    @(posedge clock); #1;
    drive(1'b1, 2'b01, rnd_vec(), rnd_vec());
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    start_cnt = out_cnt;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stale_after_reset got v=%b y=%h want v=0", bus.out_valid, cur_y());
      end
    end
    @(posedge clock); #1;
    drive(1'b1, 2'b01, rnd_vec(), rnd_vec());
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    wait_drain();
    checks++;
    if (out_cnt - start_cnt != 1) begin
      failures++;
      $display("FAIL post_reset_tx got=%0d want=1", out_cnt - start_cnt);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.out_ready = 1'b1;
    for (int l = 0; l < N; l++) begin
      bus.a[l] = '0;
      bus.b[l] = '0;
    end
    test_reset();
    test_add_wrap();
    test_saturation();
    test_backpressure();
    test_throughput();
    test_midflight_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_addsub_pipe.md
# vec_addsub_pipe

- Parametrised N-lane, W-bit vector add/subtract engine with per-transaction opcode, per-lane carry/borrow flags and optional unsigned saturation.
- The pipeline is STAGES deep, fully registered on input and output, with valid/ready handshakes on both sides.
- It is the next-generation vector datapath element, used where upstream and downstream blocks apply backpressure.

## Interface
- W, 8, lane width in bits (≥2)
- N, 4, lane count (≥1)
- STAGES, 3, pipeline depth = input-to-output latency in cycles (≥2)
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- in_valid  in  1  upstream transaction valid
- in_ready  out  1  block can accept this cycle
- in_op  in  2  opcode: 00 add, 01 sub (a−b), 10 add-sat, 11 sub-sat
- a  in  W × [N]  unpacked array of operand A lanes
- b  in  W × [N]  unpacked array of operand B lanes
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- y  out  W × [N]  unpacked array of result lanes
- out_flag  out  N  per-lane carry-out (add ops) or borrow (sub ops), bit i ↔ lane i

## Operation
- Stage 0 registers a, b, in_op and valid on acceptance (in_valid && in_ready).
- Stage 1 computes per-lane W+1-bit sum or difference from stage-0 registers. Stages 2..STAGES−1 are delay registers. The last stage drives y, out_flag and out_valid directly from flops; outputs have no combinational path from inputs.
- Arithmetic is unsigned:
  - add: y = (a+b) mod 2^W, flag = bit W of a+b.
  - sub: y = (a−b) mod 2^W, flag = 1 iff a<b.
  - add-sat: flag as add; y = 2^W−1 when flag=1.
  - sub-sat: flag as sub; y = 0 when flag=1.
- Lanes are independent; the opcode applies to all lanes of a transaction.
- Flow control:
  - Global stall: advance = !out_valid || out_ready. in_ready = advance, forced 0 while reset is asserted.
  - When advance=0, every stage holds, including bubbles.
  - While out_valid=1 && out_ready=0, y, out_flag and out_valid hold stable.
- Transfer occurs on in_valid && in_ready (input side) and on out_valid && out_ready (output side). Each accepted transaction produces exactly one output. Order is preserved. Nothing is dropped or duplicated.
- in_valid=0 when advance=1 inserts a bubble (valid=0) into stage 0.
- Reset (reset=0 at a posedge) clears all valid bits, all data/op registers, y, and out_flag to 0. In-flight transactions are discarded, including those mid-pipeline. Reset values: out_valid=0, y=0, out_flag=0, in_ready=0 during reset and 1 on the first cycle after release.

## Timing
- Latency: a transaction accepted at edge k presents out_valid=1 after edge k+STAGES−1, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput is one transaction per cycle when out_ready is held 1.
- Simultaneous output transfer and input acceptance in the same cycle is legal and required for full throughput.
- in_ready depends combinationally on out_valid (flop) and out_ready only. It has no dependence on in_valid.

## Configuration
- Macro VEC_ADDSUB_SAT_EN.
- Defined: opcodes 10/11 saturate as specified.
- Undefined: the saturation muxes are removed. Opcode 10 behaves exactly as 00 and 11 exactly as 01 (wrap results), and flags are still reported.
- The handshake and latency are identical in both builds.

## Test plan
- Reset: hold reset=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, y all 0, out_flag=0. After release, in_ready=1 and no output appears.
- Add wrap, W=8, N=4, STAGES=3: a={255,1,100,0}, b={1,2,27,0}, op=00, out_ready=1 → after 2 cycles y={0,3,127,0}, out_flag=4'b0001.
- Saturation with VEC_ADDSUB_SAT_EN defined: op=10, a={200,…}, b={100,…} → y[0]=255, flag[0]=1. Op=11, a={5}, b={9} → y=0, flag=1. With the macro undefined, the same stimulus gives y[0]=44 and y=252 respectively.
- Backpressure: stream 8 back-to-back transactions with out_ready toggling 1,0,0,1… → outputs in order, no loss or duplication, y held stable during stalls, and in_ready = !out_valid || out_ready every cycle.
- Full throughput: 16 consecutive transactions with out_ready=1 → 16 outputs on 16 consecutive cycles, with the first output after STAGES−1 cycles.
- Mid-flight reset: accept 2 transactions, then assert reset for 1 cycle before either emerges → out_valid stays 0, no stale result appears after release, and the next transaction completes normally.
